// File: rtl/serial_frame_arbiter.sv
// Serial frame arbiter: round-robin grants one of n_req serial requesters
// to a shared serial_to_parallel for exactly one width-bit frame, with
// abort on request withdrawal or on a run of idle granted cycles.
module serial_frame_arbiter #(
    parameter int n_req   = 4,
    parameter int width   = 8,
    parameter int timeout = 16,
    localparam int SRC_W  = (n_req > 1) ? $clog2(n_req) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [n_req-1:0] req,
    input  logic [n_req-1:0] serial_valid_in,
    input  logic [n_req-1:0] serial_data_in,
    output logic [n_req-1:0] grant,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             frame_done,
    output logic             frame_aborted,
    output logic             sink_flush,
    output logic [SRC_W-1:0] frame_src,
    output logic             busy
);

    localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [n_req-1:0]   grant_q;
    logic [SRC_W-1:0]   gidx_q;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic [SRC_W-1:0]   frame_src_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [7:0]         idle_cnt_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               frame_aborted_q;
    logic               sink_flush_q;

    logic [2*n_req-1:0] req_rot;
    logic               pick_vld;
    logic [SRC_W-1:0]   pick_idx;
    logic [SRC_W-1:0]   rr_ptr_d;
    logic               req_g;
    logic               last_bit;
    logic               stall_out;
    logic               abort_c;

    // Round-robin pick: rotate req so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_rot  = {req, req} >> rr_ptr_q;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < n_req; k++) begin
            if (!pick_vld && req_rot[k]) begin
                pick_vld = 1'b1;
                pick_idx = SRC_W'((int'(rr_ptr_q) + k) % n_req);
            end
        end
    end

    // Grant mux toward the shared deserializer and frame end conditions.
    always_comb begin
        serial_valid = |(serial_valid_in & grant_q);
        serial_data  = serial_valid & (|(serial_data_in & grant_q));
        req_g        = |(req & grant_q);
        last_bit     = serial_valid && (bit_cnt_q == CNT_W'(width - 1));
        stall_out    = !serial_valid && (idle_cnt_q == 8'(timeout - 1));
        abort_c      = !req_g || stall_out;
        rr_ptr_d     = (gidx_q == SRC_W'(n_req - 1)) ? '0 : gidx_q + SRC_W'(1);
    end

    // Arbiter FSM: grant, bit/idle counting, completion and abort pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            gidx_q          <= '0;
            rr_ptr_q        <= '0;
            frame_src_q     <= '0;
            bit_cnt_q       <= '0;
            idle_cnt_q      <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_aborted_q <= 1'b0;
            sink_flush_q    <= 1'b0;
        end else begin
            frame_done_q    <= 1'b0;
            frame_aborted_q <= 1'b0;
            sink_flush_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q    <= BUSY;
                        grant_q    <= n_req'(1) << pick_idx;
                        gidx_q     <= pick_idx;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= '0;
                        idle_cnt_q <= '0;
                    end
                end
                BUSY: begin
                    // A valid final bit completes the frame even if req drops with it.
                    if (last_bit || abort_c) begin
                        state_q         <= IDLE;
                        grant_q         <= '0;
                        busy_q          <= 1'b0;
                        bit_cnt_q       <= '0;
                        idle_cnt_q      <= '0;
                        rr_ptr_q        <= rr_ptr_d;
                        frame_src_q     <= gidx_q;
                        frame_done_q    <= last_bit;
                        frame_aborted_q <= !last_bit;
                        sink_flush_q    <= !last_bit;
                    end else if (serial_valid) begin
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant         = grant_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_aborted = frame_aborted_q;
    assign sink_flush    = sink_flush_q;
    assign frame_src     = frame_src_q;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Testbench for serial_frame_arbiter: directed frames with literal
// expectations followed by randomized traffic checked every cycle against a
// frame-level model of the arbiter.
module tb_serial_frame_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] sv_in;
    logic [N-1:0] sd_in;
    logic [N-1:0] grant;
    logic         serial_valid;
    logic         serial_data;
    logic         frame_done;
    logic         frame_aborted;
    logic         sink_flush;
    logic [1:0]   frame_src;
    logic         busy;

    serial_frame_arbiter #(.n_req(N), .width(W), .timeout(T)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .serial_valid_in (sv_in),
        .serial_data_in  (sd_in),
        .grant           (grant),
        .serial_valid    (serial_valid),
        .serial_data     (serial_data),
        .frame_done      (frame_done),
        .frame_aborted   (frame_aborted),
        .sink_flush      (sink_flush),
        .frame_src       (frame_src),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: who owns the channel, how many bits have landed,
    // how long the owner has been quiet, and where the next scan starts.
    int m_owner = -1;
    int m_nbits = 0;
    int m_quiet = 0;
    int m_ptr   = 0;
    int m_src   = 0;
    bit m_done  = 1'b0;
    bit m_abort = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_nbits = 0; m_quiet = 0; m_ptr = 0; m_src = 0;
            m_done = 1'b0; m_abort = 1'b0;
        end else begin
            m_done  = 1'b0;
            m_abort = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++)
                    if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_nbits = 0;
                m_quiet = 0;
            end else begin
                bit v;
                v = sv_in[m_owner];
                if (v && m_nbits == W - 1) begin
                    m_done = 1'b1;
                end else if (!req[m_owner] || (!v && m_quiet == T - 1)) begin
                    m_abort = 1'b1;
                end else if (v) begin
                    m_nbits++;
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                end
                if (m_done || m_abort) begin
                    m_src   = m_owner;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_nbits = 0;
                    m_quiet = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int exp_g;
            bit exp_sv, exp_sd;
            exp_g  = (m_owner >= 0) ? (1 << m_owner) : 0;
            exp_sv = (m_owner >= 0) && sv_in[m_owner];
            exp_sd = exp_sv && sd_in[m_owner];
            chk("grant", 32'(grant), exp_g);
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("serial_valid", 32'(serial_valid), 32'(exp_sv));
            chk("serial_data", 32'(serial_data), 32'(exp_sd));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            chk("frame_aborted", 32'(frame_aborted), 32'(m_abort));
            chk("sink_flush", 32'(sink_flush), 32'(m_abort));
            chk("frame_src", 32'(frame_src), m_src);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; sv_in = '0; sd_in = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] bits;
        int quiet_left;

        rst = 1'b1; req = '0; sv_in = '0; sd_in = '0;
        step();
        chk_en = 1'b1;
        settle();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_src", 32'(frame_src), 0);

        // Single requester, fixed bit pattern 1,0,1,1,0,0,1,0.
        rst = 1'b0; req = 4'b0001;
        bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            step();
            sv_in = 4'b0001; sd_in = {3'b000, bits[i]};
            settle();
            if (i == 0) chk("t1_grant", 32'(grant), 32'h1);
            chk("t1_data", 32'(serial_data), 32'(bits[i]));
        end
        step();
        req = '0; sv_in = '0; sd_in = '0;
        settle();
        chk("t1_done", 32'(frame_done), 1);
        chk("t1_src", 32'(frame_src), 0);
        chk("t1_grant_off", 32'(grant), 0);

        // All four requesting and streaming: rotation with one idle cycle between grants.
        do_reset();
        req = 4'hF; sv_in = 4'hF; sd_in = N'($urandom);
        for (int c = 0; c < 45; c++) begin
            step();
            req   = (c == 44) ? 4'h0 : 4'hF;
            sv_in = (c == 44) ? 4'h0 : 4'hF;
            sd_in = N'($urandom);
            settle();
            chk("t2_grant", 32'(grant), (c % 9 == 8) ? 0 : (1 << ((c / 9) % 4)));
        end
        step();
        req = '0; sv_in = '0;

        // Four bits, three-cycle gap, four bits: a single completion, no abort.
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 13; c++) begin
            step();
            sv_in = (c < 4 || (c >= 7 && c < 11)) ? 4'b0001 : 4'b0000;
            sd_in = N'($urandom);
            req   = (c >= 11) ? 4'b0000 : 4'b0001;
            settle();
            chk("t3_done", 32'(frame_done), 32'(c == 11));
            chk("t3_abort", 32'(frame_aborted), 0);
        end

        // Source 1 sends two bits then goes quiet until the timeout fires.
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            step();
            sv_in = (c < 2) ? 4'b0010 : 4'b0000;
            sd_in = N'($urandom);
            req   = (c >= 18) ? 4'hF : 4'b0010;
            settle();
            chk("t4_abort", 32'(frame_aborted), 32'(c == 18));
            chk("t4_flush", 32'(sink_flush), 32'(c == 18));
            if (c == 18) begin
                chk("t4_src", 32'(frame_src), 1);
                chk("t4_grant_off", 32'(grant), 0);
            end
            if (c == 19) chk("t4_next_grant", 32'(grant), 32'h4);
        end
        step();
        req = '0; sv_in = '0;

        // Source 2 drops its request after three bits.
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            step();
            sv_in = (c < 3) ? 4'b0100 : 4'b0000;
            req   = (c < 3) ? 4'b0100 : 4'b0000;
            sd_in = N'($urandom);
            settle();
            chk("t5_abort", 32'(frame_aborted), 32'(c == 4));
            chk("t5_done", 32'(frame_done), 0);
            if (c == 4) chk("t5_src", 32'(frame_src), 2);
        end

        // Reset in the middle of a frame from source 3.
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            step();
            sv_in = 4'b1000; sd_in = N'($urandom);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b0100; sv_in = '0;
        settle();
        chk("t6_grant", 32'(grant), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pulses", 32'({frame_done, frame_aborted, sink_flush}), 0);
        step();
        settle();
        chk("t6_regrant", 32'(grant), 32'h4);
        step();
        req = '0;

        // Randomized traffic with quiet bursts, request drops and rare resets.
        quiet_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 5) == 0);
                else if ($urandom_range(0, 199) == 0) req[i] = 1'b0;
            end
            if (m_done && $urandom_range(0, 1) == 1) req[m_src] = 1'b0;
            if (quiet_left > 0) quiet_left--;
            else if ($urandom_range(0, 49) == 0) quiet_left = $urandom_range(8, 20);
            sv_in = (quiet_left > 0) ? '0 : N'($urandom | $urandom);
            sd_in = N'($urandom);
        end
        step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
